branch_predictor: RTL and testbench

- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Sits directly upstream of the PC generator in the pipelined core:
  - each cycle it looks up the current fetch PC and supplies a predicted next PC and taken flag to the PC-select mux;
  - the branch resolution in the memory-access stage trains it.
- Purpose: replace the fixed PC+4 fall-through with taken-branch prediction.

---
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup, edge-trained.
// Optional resolved-branch / misprediction counters under `BP_STATS_EN.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispred_i,
  input  logic        clear_i
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_mispred_o
`endif
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             tag_we, tgt_we;

  // Lookup path: pure function of pc_i and current table state, no bypass.
  assign lk_idx        = pc_i[IDX_W+1:2];
  assign lk_tag        = pc_i[31:IDX_W+2];
  assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : pc_i + 32'd4;

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[31:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Training; clear wins over a same-cycle update, which is then dropped.
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_we  = 1'b0;
    tgt_we  = 1'b0;
    if (clear_i) begin
      valid_d = '0;
    end else if (upd_valid_i) begin
      if (up_hit) begin
        if (upd_taken_i) begin
          if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
          tgt_we = 1'b1;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        valid_d[up_idx] = 1'b1;
        ctr_d[up_idx]   = 2'b10;
        tag_we          = 1'b1;
        tgt_we          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tags and targets are don't-care while invalid, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (tag_we && !rst_i) tag_q[up_idx]    <= up_tag;
    if (tgt_we && !rst_i) target_q[up_idx] <= upd_target_i;
  end

`ifdef BP_STATS_EN
  logic [31:0] br_q, br_d, mp_q, mp_d;

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (upd_valid_i && (br_q != 32'hFFFF_FFFF)) br_d = br_q + 32'd1;
    if (upd_valid_i && upd_mispred_i && (mp_q != 32'hFFFF_FFFF)) mp_d = mp_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_q <= '0;
      mp_q <= '0;
    end else begin
      br_q <= br_d;
      mp_q <= mp_d;
    end
  end

  assign stat_branches_o = br_q;
  assign stat_mispred_o  = mp_q;

  logic unused_bits;
  assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{pc_i[1:0], upd_pc_i[1:0], upd_mispred_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus queues expectations, negedge monitor checks.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispred_i;
  logic        clear_i;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispred_o;
`endif

  branch_predictor #(.ENTRIES(16)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .pred_taken_o  (pred_taken_o),
    .pred_target_o (pred_target_o),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_taken_i   (upd_taken_i),
    .upd_target_i  (upd_target_i),
    .upd_mispred_i (upd_mispred_i),
    .clear_i       (clear_i)
`ifdef BP_STATS_EN
    ,
    .stat_branches_o (stat_branches_o),
    .stat_mispred_o  (stat_mispred_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          kind;   // 0 lookup, 1 stats
    int          id;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: everything queued during the current cycle is checked at the falling edge.
  always @(negedge clk_i) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (e.kind == 0) begin
        if (pred_taken_o !== e.taken || pred_target_o !== e.tgt) begin
          bad++;
          $display("FAIL lookup#%0d taken got=%0b want=%0b target got=%h want=%h",
                   e.id, pred_taken_o, e.taken, pred_target_o, e.tgt);
        end
      end else begin
`ifdef BP_STATS_EN
        if (stat_branches_o !== e.br || stat_mispred_o !== e.mp) begin
          bad++;
          $display("FAIL stats#%0d branches got=%0d want=%0d mispred got=%0d want=%0d",
                   e.id, stat_branches_o, e.br, stat_mispred_o, e.mp);
        end
`endif
      end
    end
  end

  task automatic look(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input int id);
    exp_t e;
    pc_i = pc;
    e = '{kind: 0, id: id, taken: t, tgt: tgt, br: 32'd0, mp: 32'd0};
    exp_q.push_back(e);
  endtask

`ifdef BP_STATS_EN
  task automatic stats(input logic [31:0] b, input logic [31:0] m, input int id);
    exp_t e;
    e = '{kind: 1, id: id, taken: 1'b0, tgt: 32'd0, br: b, mp: m};
    exp_q.push_back(e);
  endtask
`endif

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic mis);
    upd_valid_i   = 1'b1;
    upd_pc_i      = pc;
    upd_taken_i   = t;
    upd_target_i  = tgt;
    upd_mispred_i = mis;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    upd_valid_i   = 1'b0;
    upd_mispred_i = 1'b0;
    clear_i       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; pc_i = '0; upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
    upd_target_i = '0; upd_mispred_i = 1'b0; clear_i = 1'b0;
    @(posedge clk_i); #1;
    look(32'h100, 1'b0, 32'h104, 1);                        // during reset
    tick();
    rst_i = 1'b0;
    look(32'h100, 1'b0, 32'h104, 2); tick();

    // Allocate on a taken miss.
    upd(32'h40, 1'b1, 32'h10, 1'b0); tick();
    look(32'h40, 1'b1, 32'h10, 3); tick();

    // Saturate at 11, then hysteresis on the way down.
    repeat (3) begin upd(32'h40, 1'b1, 32'h10, 1'b0); tick(); end
    look(32'h40, 1'b1, 32'h10, 4);
    upd(32'h40, 1'b0, 32'h0, 1'b0); tick();
    look(32'h40, 1'b1, 32'h10, 5);
    upd(32'h40, 1'b0, 32'h0, 1'b0); tick();
    look(32'h40, 1'b0, 32'h44, 6);
    // Saturate at 00: two more not-taken, then one taken leaves it weak NT.
    upd(32'h40, 1'b0, 32'h0, 1'b0); tick();
    upd(32'h40, 1'b0, 32'h0, 1'b0); tick();
    upd(32'h40, 1'b1, 32'h20, 1'b0); tick();
    look(32'h40, 1'b0, 32'h44, 7);
    upd(32'h40, 1'b1, 32'h20, 1'b0); tick();
    look(32'h40, 1'b1, 32'h20, 8); tick();

    // Not-taken miss never allocates.
    upd(32'h80, 1'b0, 32'h0, 1'b0); tick();
    look(32'h80, 1'b0, 32'h84, 9); tick();

    // Aliasing on index 0; low PC bits ignored.
    upd(32'h440, 1'b1, 32'h80, 1'b0); tick();
    look(32'h40, 1'b0, 32'h44, 10); tick();
    look(32'h440, 1'b1, 32'h80, 11); tick();
    look(32'h443, 1'b1, 32'h80, 12); tick();

    // Clear beats a same-cycle update; same-cycle lookup still sees old state.
    upd(32'h40, 1'b1, 32'h10, 1'b0); tick();
    clear_i = 1'b1;
    upd(32'h40, 1'b1, 32'h30, 1'b0);
    look(32'h40, 1'b1, 32'h10, 13); tick();
    look(32'h40, 1'b0, 32'h44, 14); tick();
    look(32'h440, 1'b0, 32'h444, 15); tick();

    // No bypass: update and lookup in the same cycle.
    upd(32'h40, 1'b1, 32'h10, 1'b0);
    look(32'h40, 1'b0, 32'h44, 16); tick();
    look(32'h40, 1'b1, 32'h10, 17); tick();

    // Fall-through wraps modulo 2^32.
    look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 18); tick();

`ifdef BP_STATS_EN
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    stats(32'd0, 32'd0, 19); tick();
    upd(32'h100, 1'b1, 32'h200, 1'b1); tick();
    upd(32'h104, 1'b0, 32'h0,   1'b0); tick();
    upd(32'h108, 1'b1, 32'h300, 1'b0); tick();
    upd(32'h100, 1'b1, 32'h200, 1'b1); tick();
    upd(32'h104, 1'b0, 32'h0,   1'b0); tick();
    stats(32'd5, 32'd2, 20); tick();
    clear_i = 1'b1; tick();
    stats(32'd5, 32'd2, 21);
    look(32'h100, 1'b0, 32'h104, 22); tick();
    rst_i = 1'b1;
    stats(32'd0, 32'd0, 23);
    look(32'h40, 1'b0, 32'h44, 24); tick();
    rst_i = 1'b0; tick();
`endif

    tick();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
